// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Schedules the single register-file write port between three requesters
// (exec, load, io) and drives the 3-bit select of the writeback data mux.
// Each requester owns a 1-entry holding slot. One full slot is granted per
// cycle, and the granted entry appears on wb_we/wb_addr/wb_src one edge later.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   exec_valid/ready/addr/src  exec requester (src 000/010/011/100 legal)
//   ld_valid/ready/addr        load requester (mux select 001)
//   io_valid/ready/addr        io requester (mux select 101)
//   flush                      discard pending / incoming exec work
//   wb_we, wb_addr, wb_src     registered write port and mux select
//   src_err                    sticky flag: illegal exec_src accepted
//   busy                       any slot full or a write in flight
//
// Optional feature (macro WB_RR_EN): exec/io ties with neither side starved
// are resolved by a 1-bit round-robin pointer instead of fixed exec > io.
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int AW         = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          exec_valid,
    output logic          exec_ready,
    input  logic [AW-1:0] exec_addr,
    input  logic [2:0]    exec_src,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic          io_valid,
    output logic          io_ready,
    input  logic [AW-1:0] io_addr,
    input  logic          flush,
    output logic          wb_we,
    output logic [AW-1:0] wb_addr,
    output logic [2:0]    wb_src,
    output logic          src_err,
    output logic          busy
);

    localparam logic [3:0] SMAX    = 4'(STARVE_MAX);
    localparam logic [2:0] SRC_LD  = 3'b001;
    localparam logic [2:0] SRC_IO  = 3'b101;
    localparam logic [2:0] SRC_DEF = 3'b111;

    function automatic logic src_legal(input logic [2:0] s);
        case (s)
            3'b000, 3'b010, 3'b011, 3'b100: src_legal = 1'b1;
            default:                        src_legal = 1'b0;
        endcase
    endfunction

    // slot state
    logic          ld_full, ex_full, io_full;
    logic [AW-1:0] ld_addr_q, ex_addr_q, io_addr_q;
    logic [2:0]    ex_src_q;
    logic [3:0]    ex_wait, io_wait;

    // grant decision
    logic          ex_cand, ex_starved, io_starved;
    logic          gnt_ld, gnt_ex, gnt_io, gnt_any;
    logic [AW-1:0] wb_addr_n;
    logic [2:0]    wb_src_n;

    logic          ld_acc, ex_acc, io_acc, ex_store;

`ifdef WB_RR_EN
    // 0 favours exec, 1 favours io
    logic rr_ptr;
`endif

    // ---- stage 0: combinational grant from the held slots ----
    always_comb begin
        // A flush removes exec from this cycle's competition entirely,
        // so the grant is recomputed as if the exec slot were empty.
        ex_cand    = ex_full & ~flush;
        ex_starved = ex_cand & (ex_wait == SMAX);
        io_starved = io_full & (io_wait == SMAX);
        gnt_ld     = 1'b0;
        gnt_ex     = 1'b0;
        gnt_io     = 1'b0;
        if (ex_starved) begin
            gnt_ex = 1'b1;
        end else if (io_starved) begin
            gnt_io = 1'b1;
        end else if (ld_full) begin
            gnt_ld = 1'b1;
        end else if (ex_cand && io_full) begin
`ifdef WB_RR_EN
            if (rr_ptr) gnt_io = 1'b1;
            else        gnt_ex = 1'b1;
`else
            gnt_ex = 1'b1;
`endif
        end else if (ex_cand) begin
            gnt_ex = 1'b1;
        end else if (io_full) begin
            gnt_io = 1'b1;
        end
        gnt_any = gnt_ld | gnt_ex | gnt_io;
    end

    always_comb begin
        wb_addr_n = wb_addr;
        wb_src_n  = SRC_DEF;
        if (gnt_ld) begin
            wb_addr_n = ld_addr_q;
            wb_src_n  = SRC_LD;
        end else if (gnt_ex) begin
            wb_addr_n = ex_addr_q;
            wb_src_n  = ex_src_q;
        end else if (gnt_io) begin
            wb_addr_n = io_addr_q;
            wb_src_n  = SRC_IO;
        end
    end

    // A slot being drained this cycle can be refilled on the same edge.
    assign ld_ready   = ~ld_full | gnt_ld;
    assign exec_ready = ~ex_full | gnt_ex;
    assign io_ready   = ~io_full | gnt_io;

    assign ld_acc   = ld_valid & ld_ready;
    assign ex_acc   = exec_valid & exec_ready;
    assign io_acc   = io_valid & io_ready;
    // Illegal codes complete the handshake but never occupy the slot.
    assign ex_store = ex_acc & src_legal(exec_src) & ~flush;

    assign busy = ld_full | ex_full | io_full | wb_we;

    // ---- stage 1: slot occupancy, wait counters, registered write port ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_full <= 1'b0;
            ex_full <= 1'b0;
            io_full <= 1'b0;
            ex_wait <= 4'd0;
            io_wait <= 4'd0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_src  <= SRC_DEF;
            src_err <= 1'b0;
        end else begin
            ld_full <= (ld_full & ~gnt_ld) | ld_acc;
            ex_full <= (ex_full & ~gnt_ex & ~flush) | ex_store;
            io_full <= (io_full & ~gnt_io) | io_acc;

            if (!ex_full || gnt_ex || flush) ex_wait <= 4'd0;
            else if (ex_wait != SMAX)        ex_wait <= ex_wait + 4'd1;

            if (!io_full || gnt_io)          io_wait <= 4'd0;
            else if (io_wait != SMAX)        io_wait <= io_wait + 4'd1;

            wb_we   <= gnt_any;
            wb_addr <= wb_addr_n;
            wb_src  <= wb_src_n;

            if (ex_acc && !src_legal(exec_src)) src_err <= 1'b1;
        end
    end

`ifdef WB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_ptr <= 1'b0;
        else if (gnt_ex) rr_ptr <= 1'b1;
        else if (gnt_io) rr_ptr <= 1'b0;
    end
`endif

    // Slot payloads need no reset: they are only observed while the slot is full.
    always_ff @(posedge clk) begin
        if (ld_acc) ld_addr_q <= ld_addr;
        if (io_acc) io_addr_q <= io_addr;
        if (ex_store) begin
            ex_addr_q <= exec_addr;
            ex_src_q  <= exec_src;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int AW = 4;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          exec_valid = 1'b0, ld_valid = 1'b0, io_valid = 1'b0, flush = 1'b0;
    logic [AW-1:0] exec_addr = '0, ld_addr = '0, io_addr = '0;
    logic [2:0]    exec_src = 3'b000;
    logic          exec_ready, ld_ready, io_ready;
    logic          wb_we, src_err, busy;
    logic [AW-1:0] wb_addr;
    logic [2:0]    wb_src;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.AW(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_addr(exec_addr), .exec_src(exec_src),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .io_valid(io_valid), .io_ready(io_ready), .io_addr(io_addr),
        .flush(flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_src(wb_src),
        .src_err(src_err), .busy(busy)
    );

    // ------------------------------------------------------------------
    // Reference model: requester index 0=load, 1=exec, 2=io.
    // ------------------------------------------------------------------
    bit            m_full [3];
    logic [AW-1:0] m_addr [3];
    logic [2:0]    m_src  [3];
    int            m_wait [3];
    bit            m_rr;
    bit            m_err;
    int            m_w;
    bit            m_rdy  [3];
    bit            exp_we;
    logic [AW-1:0] exp_addr;
    logic [2:0]    exp_src;
    bit            obs_rdy [3];

    function automatic bit legal(input logic [2:0] s);
        return (s == 3'd0) || (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic bit exp_busy();
        return m_full[0] || m_full[1] || m_full[2] || exp_we;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_full[i] = 0;
            m_wait[i] = 0;
        end
        m_rr = 0; m_err = 0;
        exp_we = 0; exp_addr = '0; exp_src = 3'b111;
    endtask

    task automatic model_eval();
        bit ex_ok, st_ex, st_io;
        ex_ok = m_full[1] && !flush;
        st_ex = ex_ok && (m_wait[1] == SM);
        st_io = m_full[2] && (m_wait[2] == SM);
        if (st_ex)                     m_w = 1;
        else if (st_io)                m_w = 2;
        else if (m_full[0])            m_w = 0;
        else if (ex_ok && m_full[2]) begin
`ifdef WB_RR_EN
            m_w = m_rr ? 2 : 1;
`else
            m_w = 1;
`endif
        end
        else if (ex_ok)                m_w = 1;
        else if (m_full[2])            m_w = 2;
        else                           m_w = -1;
        for (int i = 0; i < 3; i++) m_rdy[i] = !m_full[i] || (m_w == i);
    endtask

    task automatic model_update(input bit lv, input logic [AW-1:0] la,
                                input bit ev, input logic [AW-1:0] ea, input logic [2:0] es,
                                input bit iv, input logic [AW-1:0] ia, input bit fl);
        exp_we = (m_w >= 0);
        if (m_w >= 0) begin
            exp_addr = m_addr[m_w];
            exp_src  = m_src[m_w];
        end else begin
            exp_src  = 3'b111;
        end
        for (int i = 1; i < 3; i++) begin
            if (!m_full[i] || m_w == i || (i == 1 && fl)) m_wait[i] = 0;
            else if (m_wait[i] < SM)                       m_wait[i]++;
        end
        if (m_w >= 0) m_full[m_w] = 0;
        if (fl) m_full[1] = 0;
        if (lv && m_rdy[0]) begin m_full[0] = 1; m_addr[0] = la; m_src[0] = 3'b001; end
        if (iv && m_rdy[2]) begin m_full[2] = 1; m_addr[2] = ia; m_src[2] = 3'b101; end
        if (ev && m_rdy[1]) begin
            if (!legal(es))  m_err = 1;
            else if (!fl) begin m_full[1] = 1; m_addr[1] = ea; m_src[1] = es; end
        end
`ifdef WB_RR_EN
        if (m_w == 1) m_rr = 1;
        if (m_w == 2) m_rr = 0;
`endif
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the next.
    task automatic cycle();
        bit lv, ev, iv, fl;
        logic [AW-1:0] la, ea, ia;
        logic [2:0] es;
        #2;
        model_eval();
        obs_rdy[0] = ld_ready; obs_rdy[1] = exec_ready; obs_rdy[2] = io_ready;
        lv = ld_valid; la = ld_addr; ev = exec_valid; ea = exec_addr; es = exec_src;
        iv = io_valid; ia = io_addr; fl = flush;
        @(posedge clk);
        model_update(lv, la, ev, ea, es, iv, ia, fl);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid = 0; exec_valid = 0; io_valid = 0; flush = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #12;
        model_reset();
        checks++; if (wb_we !== 1'b0)   begin errors++; $display("FAIL reset_we got=%b exp=0", wb_we); end
        checks++; if (wb_src !== 3'b111) begin errors++; $display("FAIL reset_src got=%b exp=111", wb_src); end
        checks++; if (wb_addr !== 4'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", wb_addr); end
        checks++; if (src_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags got err=%b busy=%b exp 0 0", src_err, busy); end
        checks++; if ({ld_ready, exec_ready, io_ready} !== 3'b111) begin errors++; $display("FAIL reset_ready got=%b exp=111", {ld_ready, exec_ready, io_ready}); end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_load();
        ld_valid = 1; ld_addr = 4'd3;
        cycle();
        idle_inputs();
        checks++; if (wb_we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ld_edge1 got we=%b busy=%b exp we=0 busy=1", wb_we, busy); end
        cycle();
        checks++; if (wb_we !== 1'b1 || wb_addr !== 4'd3 || wb_src !== 3'b001) begin
            errors++; $display("FAIL ld_edge2 got we=%b addr=%0d src=%b exp we=1 addr=3 src=001", wb_we, wb_addr, wb_src); end
        cycle();
        checks++; if (wb_we !== 1'b0 || wb_src !== 3'b111) begin
            errors++; $display("FAIL ld_edge3 got we=%b src=%b exp we=0 src=111", wb_we, wb_src); end
    endtask

    task automatic test_exec_io_pair();
        for (int pair = 0; pair < 2; pair++) begin
            exec_valid = 1; exec_addr = 4'd5; exec_src = 3'b100;
            io_valid = 1; io_addr = 4'd6;
            cycle();
            idle_inputs();
            for (int k = 0; k < 3; k++) begin
                cycle();
                checks++; if (wb_we !== exp_we || wb_src !== exp_src || wb_addr !== exp_addr) begin
                    errors++; $display("FAIL pair%0d_c%0d got we=%b addr=%0d src=%b exp we=%b addr=%0d src=%b",
                                       pair, k, wb_we, wb_addr, wb_src, exp_we, exp_addr, exp_src); end
            end
        end
    endtask

    task automatic test_starvation();
        int grant_no = 0;
        int io_at = -1;
        io_valid = 1; io_addr = 4'd9;
        ld_valid = 1; ld_addr = 4'd1;
        cycle();
        io_valid = 0;
        for (int k = 0; k < 8; k++) begin
            ld_addr = 4'(k + 2);
            cycle();
            checks++; if (wb_we !== exp_we || wb_src !== exp_src || wb_addr !== exp_addr) begin
                errors++; $display("FAIL starve_c%0d got we=%b addr=%0d src=%b exp we=%b addr=%0d src=%b",
                                   k, wb_we, wb_addr, wb_src, exp_we, exp_addr, exp_src); end
            if (wb_we) grant_no++;
            if (wb_we && wb_src == 3'b101 && io_at < 0) io_at = grant_no;
        end
        checks++; if (io_at != 5) begin errors++; $display("FAIL starve_io_grant got=%0d exp=5", io_at); end
        idle_inputs();
        repeat (3) cycle();
    endtask

    task automatic test_src_err();
        exec_valid = 1; exec_addr = 4'd7; exec_src = 3'b110;
        cycle();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (wb_we !== 1'b0 || src_err !== 1'b1) begin
                errors++; $display("FAIL srcerr_c%0d got we=%b err=%b exp we=0 err=1", k, wb_we, src_err); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL srcerr_busy got=%b exp=0", busy); end
    endtask

    task automatic test_flush();
        exec_valid = 1; exec_addr = 4'd2; exec_src = 3'b000;
        cycle();
        exec_valid = 0; flush = 1;
        cycle();
        flush = 0;
        checks++; if (wb_we !== 1'b0 || wb_we !== exp_we) begin errors++; $display("FAIL flush_we got=%b exp=0", wb_we); end
        checks++; if (busy !== 1'b0 || exec_ready !== 1'b1) begin errors++; $display("FAIL flush_state got busy=%b rdy=%b exp busy=0 rdy=1", busy, exec_ready); end
    endtask

    task automatic test_back_to_back();
        ld_valid = 1;
        for (int k = 0; k < 6; k++) begin
            ld_addr = 4'($urandom_range(15));
            cycle();
            checks++; if (obs_rdy[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_c%0d got=%b exp=1", k, obs_rdy[0]); end
            if (k > 0) begin
                checks++; if (wb_we !== 1'b1 || wb_addr !== exp_addr || wb_src !== 3'b001) begin
                    errors++; $display("FAIL b2b_write_c%0d got we=%b addr=%0d src=%b exp we=1 addr=%0d src=001",
                                       k, wb_we, wb_addr, wb_src, exp_addr); end
            end
        end
        rst = 1;
        #1;
        checks++; if (wb_we !== 1'b0 || wb_src !== 3'b111 || busy !== 1'b0 || src_err !== 1'b0) begin
            errors++; $display("FAIL midrst got we=%b src=%b busy=%b err=%b exp 0 111 0 0", wb_we, wb_src, busy, src_err); end
        model_reset();
        idle_inputs();
        #2 rst = 0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            ld_valid   = ($urandom_range(3) != 0);
            ld_addr    = 4'($urandom);
            io_valid   = ($urandom_range(1) != 0);
            io_addr    = 4'($urandom);
            exec_valid = ($urandom_range(1) != 0);
            exec_addr  = 4'($urandom);
            case ($urandom_range(3))
                0: exec_src = 3'b000;
                1: exec_src = 3'b010;
                2: exec_src = 3'b011;
                default: exec_src = 3'b100;
            endcase
            if (k > 300 && $urandom_range(40) == 0) exec_src = 3'b111;
            flush = ($urandom_range(7) == 0);
            cycle();
            checks++; if (obs_rdy[0] !== m_rdy[0] || obs_rdy[1] !== m_rdy[1] || obs_rdy[2] !== m_rdy[2]) begin
                errors++; $display("FAIL rnd_ready_c%0d got=%b%b%b exp=%b%b%b", k,
                                   obs_rdy[0], obs_rdy[1], obs_rdy[2], m_rdy[0], m_rdy[1], m_rdy[2]); end
            checks++; if (wb_we !== exp_we || wb_addr !== exp_addr || wb_src !== exp_src) begin
                errors++; $display("FAIL rnd_wb_c%0d got we=%b addr=%0d src=%b exp we=%b addr=%0d src=%b",
                                   k, wb_we, wb_addr, wb_src, exp_we, exp_addr, exp_src); end
            checks++; if (busy !== exp_busy() || src_err !== m_err) begin
                errors++; $display("FAIL rnd_flags_c%0d got busy=%b err=%b exp busy=%b err=%b",
                                   k, busy, src_err, exp_busy(), m_err); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_exec_io_pair();
        test_starvation();
        test_src_err();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
